// File: rtl/useq.sv
// Microcode sequencer: computes the next microcode ROM address from the control word,
// with a return stack, finisher register, WAIT/HALT handling and NMI/IRQ vectoring.
module useq #(
    parameter int unsigned AW       = 9,
    parameter int unsigned NIRQ     = 4,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned FIN_BASE = 'h140,
    parameter int unsigned VEC_BASE = 'h1E0,
    parameter int unsigned RST_VEC  = 'h1F0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rdy,
    input  logic [7:0]      db,
    input  logic [2:0]      uc_seq,
    input  logic [AW-2:0]   uc_next,
    input  logic [4:0]      uc_fin,
    input  logic [NIRQ-1:0] irq,
    input  logic            i_flag,
    input  logic            nmi,
    output logic [AW-1:0]   uaddr,
    output logic            sync,
    output logic [NIRQ:0]   int_ack,
    output logic            halted,
    output logic            waiting,
    output logic            err
);

    localparam int unsigned SPW = $clog2(DEPTH + 1);
    localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned IDW = $clog2(NIRQ + 1);
    localparam int unsigned AKW = NIRQ + 1;

    typedef enum logic [2:0] {
        OP_FETCH     = 3'b000,
        OP_NEXT      = 3'b001,
        OP_FINISH    = 3'b010,
        OP_NEXT_SAVE = 3'b011,
        OP_CALL      = 3'b100,
        OP_RET       = 3'b101,
        OP_WAIT      = 3'b110,
        OP_HALT      = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_HALT = 2'd2
    } state_e;

    state_e         state, state_nxt;
    logic [AW-1:0]  cur;
    logic [AW-1:0]  stk [DEPTH];
    logic [SPW-1:0] sp;
    logic [4:0]     fin;
    logic           nmi_q, take_nmi;

    op_e            op;
    logic           wake, empty, full, fetch_like, int_pend, take_ack;
    logic [IDW-1:0] id;
    logic [AW-1:0]  nxt_addr, top, jump;

    // Next-address selection, interrupt arbitration and next-state logic
    always_comb begin
        op         = op_e'(uc_seq);
        state_nxt  = state;
        id         = '0;
        int_pend   = take_nmi;
        empty      = (sp == '0);
        full       = (sp == SPW'(DEPTH));
        wake       = (|irq) | take_nmi;
        jump       = {1'b1, uc_next};
        top        = stk[IW'(sp - SPW'(1))];
        nxt_addr   = cur;

        if (state == S_HALT) begin
            op = OP_HALT;
        end else if (state == S_WAIT) begin
            op = OP_WAIT;
        end

        // Lowest-numbered irq wins; NMI pre-empts all of them
        if (!take_nmi && !i_flag) begin
            for (int k = NIRQ - 1; k >= 0; k--) begin
                if (irq[k]) begin
                    id       = IDW'(k + 1);
                    int_pend = 1'b1;
                end
            end
        end

        // An underflowing RET degrades to an instruction fetch
        fetch_like = (op == OP_FETCH) || ((op == OP_RET) && empty);

        case (op)
            OP_NEXT, OP_NEXT_SAVE, OP_CALL: nxt_addr = jump;
            OP_FINISH: nxt_addr = AW'(FIN_BASE + 32'(fin));
            OP_RET:    nxt_addr = top;
            OP_WAIT:   nxt_addr = wake ? jump : cur;
            default:   nxt_addr = cur;
        endcase
        if (fetch_like) begin
            nxt_addr = int_pend ? AW'(VEC_BASE + 32'(id)) : AW'(db);
        end

        take_ack = rdy & fetch_like & int_pend;

        if (rdy) begin
            case (op)
                OP_HALT: state_nxt = S_HALT;
                OP_WAIT: state_nxt = wake ? S_RUN : S_WAIT;
                default: state_nxt = S_RUN;
            endcase
        end
    end

    always_comb begin
        uaddr   = reset ? nxt_addr : AW'(RST_VEC);
        sync    = reset & fetch_like;
        int_ack = (reset && take_ack) ? (AKW'(1) << id) : '0;
        halted  = reset & (op == OP_HALT);
        waiting = reset & (op == OP_WAIT) & ~wake;
    end

    // NMI edge capture runs regardless of rdy; everything else advances only on rdy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_RUN;
            cur      <= AW'(RST_VEC);
            sp       <= '0;
            fin      <= '0;
            err      <= 1'b0;
            nmi_q    <= 1'b0;
            take_nmi <= 1'b0;
        end else begin
            nmi_q    <= nmi;
            take_nmi <= (nmi & ~nmi_q) | (take_nmi & ~take_ack);
            if (rdy) begin
                state <= state_nxt;
                cur   <= nxt_addr;
                if (op == OP_NEXT_SAVE) begin
                    fin <= uc_fin;
                end
                if (op == OP_CALL) begin
                    if (full) begin
                        err <= 1'b1;
                    end else begin
                        sp <= sp + SPW'(1);
                    end
                end
                if (op == OP_RET) begin
                    if (empty) begin
                        err <= 1'b1;
                    end else begin
                        sp <= sp - SPW'(1);
                    end
                end
            end
        end
    end

    // Stack storage needs no reset: the pointer defines which entries are valid
    always_ff @(posedge clk) begin
        if (reset && rdy && (op == OP_CALL) && !full) begin
            stk[IW'(sp)] <= cur + AW'(1);
        end
    end

endmodule

// File: tb/tb_useq.sv
// Bench for useq: directed vector table, hand-written corner sequences and
// randomized stimulus against a queue-based behavioural model.
module tb_useq;

    localparam int NIRQ  = 4;
    localparam int DEPTH = 4;

    logic       clk, reset, rdy, i_flag, nmi;
    logic [7:0] db, uc_next;
    logic [2:0] uc_seq;
    logic [4:0] uc_fin;
    logic [3:0] irq;
    logic [8:0] uaddr;
    logic       sync, halted, waiting, err;
    logic [4:0] int_ack;

    useq dut (
        .clk(clk), .reset(reset), .rdy(rdy), .db(db), .uc_seq(uc_seq),
        .uc_next(uc_next), .uc_fin(uc_fin), .irq(irq), .i_flag(i_flag),
        .nmi(nmi), .uaddr(uaddr), .sync(sync), .int_ack(int_ack),
        .halted(halted), .waiting(waiting), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model state: mode 0=running, 1=waiting, 2=halted
    int m_cur, m_fin, m_mode;
    int m_stk[$];
    bit m_err, m_nq, m_take;
    int e_uaddr, e_ack, e_op, e_id;
    bit e_sync, e_halt, e_wait, e_err, e_fetch, e_wake;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cur = 'h1F0; m_fin = 0; m_mode = 0; m_stk.delete();
        m_err = 0; m_nq = 0; m_take = 0;
    endtask

    task automatic model_eval();
        e_ack = 0;
        if (!reset) begin
            e_uaddr = 'h1F0; e_sync = 0; e_halt = 0; e_wait = 0; e_err = 0;
            e_fetch = 0; e_op = 0; e_id = -1; e_wake = 0;
            return;
        end
        e_op   = (m_mode == 2) ? 7 : (m_mode == 1) ? 6 : int'(uc_seq);
        e_wake = (irq != 0) || m_take;
        e_id   = -1;
        if (m_take) e_id = 0;
        else if (!i_flag) begin
            for (int k = NIRQ - 1; k >= 0; k--) if (irq[k]) e_id = k + 1;
        end
        e_fetch = (e_op == 0) || (e_op == 5 && m_stk.size() == 0);
        e_sync  = e_fetch;
        e_halt  = (e_op == 7);
        e_wait  = (e_op == 6) && !e_wake;
        e_err   = m_err;
        if (e_fetch) begin
            e_uaddr = (e_id >= 0) ? (('h1E0 + e_id) % 512) : int'(db);
            if (e_id >= 0 && rdy) e_ack = 1 << e_id;
        end else begin
            case (e_op)
                1, 3, 4: e_uaddr = 256 + int'(uc_next);
                2:       e_uaddr = ('h140 + m_fin) % 512;
                5:       e_uaddr = m_stk[$];
                6:       e_uaddr = e_wake ? 256 + int'(uc_next) : m_cur;
                default: e_uaddr = m_cur;
            endcase
        end
    endtask

    task automatic model_update();
        bit taken;
        if (!reset) begin
            model_reset();
            return;
        end
        taken  = rdy && e_fetch && (e_id == 0);
        m_take = (nmi && !m_nq) || (m_take && !taken);
        m_nq   = nmi;
        if (rdy) begin
            if (e_op == 4) begin
                if (m_stk.size() < DEPTH) m_stk.push_back((m_cur + 1) % 512);
                else m_err = 1;
            end
            if (e_op == 5) begin
                if (m_stk.size() == 0) m_err = 1;
                else void'(m_stk.pop_back());
            end
            if (e_op == 3) m_fin = int'(uc_fin);
            m_mode = (e_op == 7) ? 2 : (e_op == 6) ? (e_wake ? 0 : 1) : 0;
            m_cur  = e_uaddr;
        end
    endtask

    // Drive one cycle's inputs (at the falling edge) and check against the model
    task automatic drive(input logic [2:0] s, input logic [7:0] nx, input logic [4:0] f,
                         input logic [7:0] d, input logic [3:0] q, input logic fi,
                         input logic n, input logic r);
        uc_seq = s; uc_next = nx; uc_fin = f; db = d; irq = q; i_flag = fi; nmi = n; rdy = r;
        #1;
        if (!reset) model_reset();
        model_eval();
        chk("m_uaddr", int'(uaddr), e_uaddr);
        chk("m_sync", int'(sync), int'(e_sync));
        chk("m_int_ack", int'(int_ack), e_ack);
        chk("m_halted", int'(halted), int'(e_halt));
        chk("m_waiting", int'(waiting), int'(e_wait));
        chk("m_err", int'(err), int'(e_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(3'd0, 8'h00, 5'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("rst_uaddr", int'(uaddr), 'h1F0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    typedef struct {
        logic [2:0] seq;
        logic [7:0] nx;
        logic [4:0] f;
        logic [7:0] d;
        logic [3:0] q;
        logic       fi, n, r;
        logic [8:0] ea;
        logic       es;
        logic [4:0] ek;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{3'd0, 8'h00, 5'h00, 8'hA9, 4'b0000, 1'b0, 1'b0, 1'b1, 9'h0A9, 1'b1, 5'b00000};
        tbl[1] = '{3'd3, 8'h10, 5'h03, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b1, 9'h110, 1'b0, 5'b00000};
        tbl[2] = '{3'd2, 8'h00, 5'h00, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b1, 9'h143, 1'b0, 5'b00000};
        tbl[3] = '{3'd1, 8'h55, 5'h00, 8'h00, 4'b0010, 1'b0, 1'b1, 1'b1, 9'h155, 1'b0, 5'b00000};
        tbl[4] = '{3'd0, 8'h00, 5'h00, 8'h00, 4'b0010, 1'b0, 1'b1, 1'b1, 9'h1E0, 1'b1, 5'b00001};
        tbl[5] = '{3'd0, 8'h00, 5'h00, 8'h00, 4'b0010, 1'b0, 1'b0, 1'b1, 9'h1E2, 1'b1, 5'b00100};
        tbl[6] = '{3'd0, 8'h00, 5'h00, 8'h3C, 4'b0010, 1'b1, 1'b0, 1'b1, 9'h03C, 1'b1, 5'b00000};
        tbl[7] = '{3'd0, 8'h00, 5'h00, 8'h00, 4'b0001, 1'b0, 1'b0, 1'b0, 9'h1E1, 1'b1, 5'b00000};
        tbl[8] = '{3'd0, 8'h00, 5'h00, 8'h00, 4'b1000, 1'b0, 1'b0, 1'b1, 9'h1E4, 1'b1, 5'b10000};
        tbl[9] = '{3'd2, 8'h00, 5'h00, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b1, 9'h143, 1'b0, 5'b00000};

        reset = 1'b0; rdy = 1'b0; db = '0; uc_seq = '0; uc_next = '0; uc_fin = '0;
        irq = '0; i_flag = 1'b0; nmi = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();
        chk("rst_err", int'(err), 0);

        // Directed table: fetch, finisher, NMI/IRQ priority, masking, rdy gating
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].seq, tbl[i].nx, tbl[i].f, tbl[i].d, tbl[i].q, tbl[i].fi, tbl[i].n, tbl[i].r);
            chk($sformatf("tbl%0d_uaddr", i), int'(uaddr), int'(tbl[i].ea));
            chk($sformatf("tbl%0d_sync", i), int'(sync), int'(tbl[i].es));
            chk($sformatf("tbl%0d_ack", i), int'(int_ack), int'(tbl[i].ek));
            tick();
        end

        // Stack overflow then underflow
        do_reset();
        drive(3'd1, 8'h05, 5'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("seq_next_105", int'(uaddr), 'h105);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(3'd4, 8'(8'h20 + i), 5'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1);
            chk($sformatf("call%0d_uaddr", i), int'(uaddr), 'h120 + i);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(3'd5, 8'h00, 5'h00, 8'h11, 4'h0, 1'b0, 1'b0, 1'b1);
            chk($sformatf("ret%0d_err", i), int'(err), 1);
            if (i == 3) chk("ret4_uaddr", int'(uaddr), 'h106);
            if (i == 4) begin
                chk("ret5_sync", int'(sync), 1);
                chk("ret5_uaddr", int'(uaddr), 'h011);
            end
            tick();
        end

        // WAIT with interrupts masked still wakes on irq, without acknowledging
        do_reset();
        drive(3'd1, 8'h30, 5'h00, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(3'd6, 8'h77, 5'h00, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1);
            chk("wait_hold", int'(uaddr), 'h130);
            chk("wait_flag", int'(waiting), 1);
            tick();
        end
        drive(3'd6, 8'h77, 5'h00, 8'h00, 4'b1000, 1'b1, 1'b0, 1'b1);
        chk("wake_uaddr", int'(uaddr), 'h177);
        chk("wake_ack", int'(int_ack), 0);
        chk("wake_waiting", int'(waiting), 0);
        tick();
        drive(3'd0, 8'h00, 5'h00, 8'h42, 4'h0, 1'b1, 1'b0, 1'b1);
        chk("post_wake_fetch", int'(uaddr), 'h042);
        tick();

        // rdy low suppresses acknowledge; reset releases HALT
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(3'd0, 8'h00, 5'h00, 8'h00, 4'b0001, 1'b0, 1'b0, 1'b0);
            chk("rdy0_ack", int'(int_ack), 0);
            tick();
        end
        drive(3'd7, 8'h00, 5'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("halt_flag", int'(halted), 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(3'd0, 8'h9A, 5'h00, 8'h00, 4'b0011, 1'b0, 1'(i), 1'b1);
            chk("halt_hold", int'(uaddr), 'h1F0);
            chk("halt_noack", int'(int_ack), 0);
            chk("halt_stay", int'(halted), 1);
            tick();
        end
        reset = 1'b0;
        drive(3'd7, 8'h00, 5'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("halt_rst_uaddr", int'(uaddr), 'h1F0);
        chk("halt_rst_halted", int'(halted), 0);
        tick();
        reset = 1'b1;
        drive(3'd0, 8'h00, 5'h00, 8'h0F, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("post_halt_uaddr", int'(uaddr), 'h00F);
        chk("post_halt_halted", int'(halted), 0);
        tick();

        // Randomized run against the model, with occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] s;
            s = 3'($urandom_range(0, 7));
            if (s == 3'd7 && $urandom_range(0, 9) != 0) s = 3'd0;
            reset = ($urandom_range(0, 59) != 0);
            drive(s, 8'($urandom), 5'($urandom), 8'($urandom),
                  ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
                  1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
